// File: rtl/instruction_prefetch_unit_pkg.sv
// Shared constants and types for the instruction prefetch front end.
package instruction_prefetch_unit_pkg;

    localparam int WORD_WIDTH = 32;
    localparam int PC_STRIDE = 4;
    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0000;

    typedef enum logic {
        FETCH,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/instruction_prefetch_unit_if.sv
// Bundles the instruction-memory handshake and the downstream fetch outputs.
interface instruction_prefetch_unit_if #(
    parameter int WORD_WIDTH = instruction_prefetch_unit_pkg::WORD_WIDTH
);

    logic                  imem_request;
    logic [WORD_WIDTH-1:0] imem_address;
    logic                  imem_ready;
    logic                  imem_valid;
    logic [WORD_WIDTH-1:0] imem_data;
    logic                  stall;
    logic                  branch_check;
    logic [WORD_WIDTH-1:0] branch_address;
    logic                  instruction_valid;
    logic [WORD_WIDTH-1:0] PC;
    logic [WORD_WIDTH-1:0] instruction;

    modport master (
        output imem_request, imem_address, instruction_valid, PC, instruction,
        input  imem_ready, imem_valid, imem_data, stall, branch_check, branch_address
    );

    modport slave (
        input  imem_request, imem_address, instruction_valid, PC, instruction,
        output imem_ready, imem_valid, imem_data, stall, branch_check, branch_address
    );

endinterface

// File: rtl/instruction_prefetch_unit_prefetch_fifo.sv
// Synchronous FIFO holding {PC, instruction} pairs; pointers carry an extra wrap bit.
module instruction_prefetch_unit_prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push && !reset && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head_data = mem[rd_ptr[AW-1:0]];
    assign count     = wr_ptr - rd_ptr;
    assign empty     = (wr_ptr == rd_ptr);

endmodule

// File: rtl/instruction_prefetch_unit.sv
// Prefetch front end: credit-limited sequential fetch, in-order response queue,
// stall hold and branch redirect with draining of stale responses.
module instruction_prefetch_unit #(
    parameter int                    DEPTH      = 4,
    parameter int                    WORD_WIDTH = instruction_prefetch_unit_pkg::WORD_WIDTH,
    parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0
) (
    input logic                       clock,
    input logic                       reset,
    instruction_prefetch_unit_if.master bus
);

    import instruction_prefetch_unit_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [WORD_WIDTH-1:0] STRIDE     = WORD_WIDTH'(PC_STRIDE);
    localparam logic [WORD_WIDTH-1:0] ALIGN_MASK = ~WORD_WIDTH'(PC_STRIDE - 1);

    fetch_state_t              state;
    fetch_state_t              state_next;
    logic [WORD_WIDTH-1:0]     fetch_pc;
    logic [WORD_WIDTH-1:0]     resp_pc;
    logic [CW-1:0]             outstanding;
    logic [CW-1:0]             outstanding_next;
    logic [CW-1:0]             occupancy;
    logic                      request;
    logic                      accept;
    logic                      push;
    logic                      pop;
    logic                      fifo_empty;
    logic [2*WORD_WIDTH-1:0]   head;

    // Each outstanding request reserves a queue slot, so a push can never overflow.
    always_comb begin
        state_next       = state;
        request          = 1'b0;
        accept           = 1'b0;
        push             = 1'b0;
        pop              = 1'b0;
        outstanding_next = outstanding;

        if (!reset && state == FETCH && !bus.branch_check)
            request = ({1'b0, outstanding} + {1'b0, occupancy}) < (CW+1)'(DEPTH);
        accept           = request && bus.imem_ready;
        outstanding_next = outstanding + CW'(accept) - CW'(bus.imem_valid);
        push             = (state == FETCH) && bus.imem_valid && !bus.branch_check;
        pop              = !fifo_empty && !bus.stall && !bus.branch_check;

        if (bus.branch_check)
            state_next = (outstanding_next != '0) ? DRAIN : FETCH;
        else if (state == DRAIN && outstanding_next == '0)
            state_next = FETCH;
    end

    // resp_pc follows the PC of the next expected response; a redirect realigns it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_next;
            if (bus.branch_check) begin
                fetch_pc <= bus.branch_address & ALIGN_MASK;
                resp_pc  <= bus.branch_address & ALIGN_MASK;
            end else begin
                if (accept) fetch_pc <= fetch_pc + STRIDE;
                if (push)   resp_pc  <= resp_pc + STRIDE;
            end
        end
    end

    instruction_prefetch_unit_prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * WORD_WIDTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (bus.branch_check),
        .push      (push),
        .pop       (pop),
        .push_data ({resp_pc, bus.imem_data}),
        .head_data (head),
        .empty     (fifo_empty),
        .count     (occupancy)
    );

    assign bus.imem_request      = request;
    assign bus.imem_address      = fetch_pc;
    assign bus.instruction_valid = !fifo_empty;
    assign bus.PC                = fifo_empty ? '0 : head[2*WORD_WIDTH-1:WORD_WIDTH];
    assign bus.instruction       = fifo_empty ? WORD_WIDTH'(NOP_INSTRUCTION) : head[WORD_WIDTH-1:0];

endmodule
